id_ex_stage: RTL and testbench

- Operand-capture pipeline register between decode/register-file read and execute in the RISC-V core.
- Captures decoded fields and the REG_FILE read data (REG_A/REG_B) into the ID/EX register.
- Resolves RAW hazards: forwards from EX, MEM and WB; inserts a one-cycle bubble on a load-use dependence.
- Honours downstream stall and branch flush.

---
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
//==============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register for the RISC-V core. Captures decoded
//            fields, resolves source operands (EX > MEM > WB > register file),
//            inserts a one-cycle bubble on load-use and honours EX stall/flush.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    // decode side
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_load,
    input  logic              id_we,
    // register file read data
    input  logic [XLEN-1:0]   reg_a,
    input  logic [XLEN-1:0]   reg_b,
    // forwarding sources
    input  logic              exr_valid,
    input  logic [XLEN-1:0]   exr_data,
    input  logic              mem_we,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    // downstream control
    input  logic              ex_stall,
    input  logic              ex_flush,
    // outputs
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_is_load,
    output logic              ex_we
);

    logic            ex_fwd_en;
    logic            load_use;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Operand priority: x0, then youngest producer (EX), MEM, WB, register file.
    // The rd==0 case needs no explicit test: rs is nonzero whenever a match is tried.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_en,
        input logic [4:0]      ex_dst,
        input logic [XLEN-1:0] ex_res,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] val;
        if (rs == 5'd0)                  val = '0;
        else if (ex_en && ex_dst == rs)  val = ex_res;
        else if (m_we && m_rd == rs)     val = m_data;
        else if (w_we && w_rd == rs)     val = w_data;
        else                             val = rf_val;
        return val;
    endfunction

    // Hazard detection, stall request and operand resolution.
    always_comb begin
        ex_fwd_en = ex_valid & ex_we & exr_valid & ~ex_is_load;
        load_use  = ex_valid & ex_is_load & ex_we & (ex_rd != 5'd0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        // Forced low while reset is asserted so decode is released together
        // with the cleared stage.
        id_stall  = rst_n & ~ex_flush & (ex_stall | load_use);
        rs1_val   = resolve(id_rs1, reg_a, ex_fwd_en, ex_rd, exr_data,
                            mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
        rs2_val   = resolve(id_rs2, reg_b, ex_fwd_en, ex_rd, exr_data,
                            mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data);
    end

    // Stage register: flush > stall hold > load-use bubble > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_imm     <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= '0;
            ex_is_load <= 1'b0;
            ex_we      <= 1'b0;
        end else if (ex_flush) begin
            ex_valid   <= 1'b0;
        end else if (ex_stall) begin
            ex_valid   <= ex_valid;
        end else if (load_use) begin
            ex_valid   <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_imm     <= id_imm;
            ex_rs1_val <= rs1_val;
            ex_rs2_val <= rs2_val;
            ex_rd      <= id_rd;
            ex_ctrl    <= id_ctrl;
            ex_is_load <= id_is_load;
            ex_we      <= id_we;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//==============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage: directed scenarios plus a
//            randomized run against a behavioural model of the stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_imm, reg_a, reg_b, exr_data, mem_data, wb_data;
    logic [4:0]        id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_is_load, id_we, exr_valid, mem_we, wb_we, ex_stall, ex_flush;
    logic              id_stall, ex_valid, ex_is_load, ex_we;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_is_load(id_is_load), .id_we(id_we),
        .reg_a(reg_a), .reg_b(reg_b),
        .exr_valid(exr_valid), .exr_data(exr_data),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load), .ex_we(ex_we)
    );

    always #5 clk = ~clk;

    // Behavioural view of the instruction sitting in the EX stage.
    typedef struct {
        bit              valid;
        bit [XLEN-1:0]   pc, imm, a, b;
        bit [4:0]        rd;
        bit [CTRL_W-1:0] ctrl;
        bit              is_load, we;
    } slot_t;

    slot_t m;

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_imm = 0;
        id_ctrl = 0; id_is_load = 0; id_we = 0; reg_a = 0; reg_b = 0;
        exr_valid = 0; exr_data = 0; mem_we = 0; mem_rd = 0; mem_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ex_stall = 0; ex_flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [XLEN-1:0] pc, input bit [4:0] rd, input bit ld);
        id_valid = 1; id_pc = pc; id_rd = rd; id_we = 1; id_is_load = ld;
        id_rs1 = 0; id_rs2 = 0;
    endtask

    // Operand value from the spec's producer list, youngest first.
    function automatic bit [XLEN-1:0] model_operand(input slot_t s, input bit [4:0] rs,
                                                    input bit [XLEN-1:0] rf);
        bit              hit  [3];
        bit [XLEN-1:0]   data [3];
        if (rs == 0) return 0;
        hit[0] = s.valid && s.we && exr_valid && !s.is_load && s.rd == rs; data[0] = exr_data;
        hit[1] = mem_we && mem_rd == rs;                                    data[1] = mem_data;
        hit[2] = wb_we && wb_rd == rs;                                      data[2] = wb_data;
        foreach (hit[i]) if (hit[i]) return data[i];
        return rf;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        tests++;
        if ({ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rd, ex_ctrl, ex_is_load, ex_we} !== '0
            || id_stall !== 1'b0) begin
            fails++; $display("FAIL reset_init: ex_valid=%b ex_pc=%h id_stall=%b want all 0",
                              ex_valid, ex_pc, id_stall);
        end
        tick(); rst_n = 1;
        issue(32'h100, 5'd3, 0);
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin
            fails++; $display("FAIL reset_first_issue: ex_valid=%b ex_pc=%h want 1/00000100",
                              ex_valid, ex_pc);
        end
    endtask

    task automatic test_forward_priority();
        bit [XLEN-1:0] want [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        idle_inputs();
        issue(32'h140, 5'd5, 0);
        tick();
        id_rs1 = 5; exr_valid = 1; exr_data = 32'h11;
        mem_we = 1; mem_rd = 5; mem_data = 32'h22;
        wb_we = 1; wb_rd = 5; wb_data = 32'h33; reg_a = 32'h44;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) exr_valid = 0;
            if (k == 2) mem_we = 0;
            if (k == 3) wb_we = 0;
            tick();
            tests++;
            if (ex_rs1_val !== want[k]) begin
                fails++; $display("FAIL fwd_priority_%0d: ex_rs1_val=%h want %h", k, ex_rs1_val, want[k]);
            end
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        issue(32'h180, 5'd1, 0);
        id_rs2 = 0; wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF; reg_b = 32'h1234;
        tick();
        tests++;
        if (ex_rs2_val !== 32'h0) begin
            fails++; $display("FAIL x0_source: ex_rs2_val=%h want 0", ex_rs2_val);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        issue(32'h1C0, 5'd7, 1);
        tick();
        issue(32'h200, 5'd8, 0);
        id_rs1 = 1; id_rs2 = 7; reg_b = 32'hDEAD;
        #1;
        tests++;
        if (id_stall !== 1'b1) begin
            fails++; $display("FAIL load_use_stall: id_stall=%b want 1", id_stall);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0 || id_stall !== 1'b0) begin
            fails++; $display("FAIL load_use_bubble: ex_valid=%b id_stall=%b want 0/0", ex_valid, id_stall);
        end
        mem_we = 1; mem_rd = 7; mem_data = 32'hCAFE_0000;
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_rs2_val !== 32'hCAFE_0000) begin
            fails++; $display("FAIL load_use_capture: ex_valid=%b ex_pc=%h ex_rs2_val=%h want 1/200/cafe0000",
                              ex_valid, ex_pc, ex_rs2_val);
        end
    endtask

    // Runs right after test_load_use, so EX holds pc 0x200 / rs2 0xCAFE0000.
    task automatic test_stall();
        idle_inputs();
        ex_stall = 1;
        issue(32'h300, 5'd9, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (id_stall !== 1'b1) begin
                fails++; $display("FAIL stall_id_stall_%0d: id_stall=%b want 1", k, id_stall);
            end
            tick();
            tests++;
            if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_rs2_val !== 32'hCAFE_0000 || ex_rd !== 5'd8) begin
                fails++; $display("FAIL stall_hold_%0d: ex_valid=%b ex_pc=%h ex_rs2_val=%h ex_rd=%0d want 1/200/cafe0000/8",
                                  k, ex_valid, ex_pc, ex_rs2_val, ex_rd);
            end
        end
        ex_stall = 0;
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_rd !== 5'd9) begin
            fails++; $display("FAIL stall_release: ex_valid=%b ex_pc=%h ex_rd=%0d want 1/300/9", ex_valid, ex_pc, ex_rd);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        issue(32'h340, 5'd9, 1);
        tick();
        issue(32'h380, 5'd10, 0);
        id_rs1 = 9; ex_stall = 1; ex_flush = 1;
        #1;
        tests++;
        if (id_stall !== 1'b0) begin
            fails++; $display("FAIL flush_id_stall: id_stall=%b want 0", id_stall);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0) begin
            fails++; $display("FAIL flush_kill: ex_valid=%b want 0", ex_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        issue(32'h400, 5'd4, 0);
        tick();
        ex_stall = 1;
        #2 rst_n = 0;
        #1;
        tests++;
        if ({ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rd, ex_ctrl, ex_is_load, ex_we} !== '0
            || id_stall !== 1'b0) begin
            fails++; $display("FAIL reset_mid_stall: ex_valid=%b ex_pc=%h ex_rd=%0d id_stall=%b want all 0",
                              ex_valid, ex_pc, ex_rd, id_stall);
        end
        tick();
        rst_n = 1; ex_stall = 0;
        issue(32'h440, 5'd2, 0);
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h440) begin
            fails++; $display("FAIL reset_release: ex_valid=%b ex_pc=%h want 1/440", ex_valid, ex_pc);
        end
    endtask

    task automatic test_random();
        bit lu, want_stall;
        idle_inputs();
        rst_n = 0; #2; rst_n = 1;
        m = '{default: 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            tests++;
            if (ex_valid !== m.valid) begin
                fails++; $display("FAIL rand_valid cyc %0d: ex_valid=%b want %b", cyc, ex_valid, m.valid);
            end
            if (m.valid) begin
                tests++;
                if ({ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, ex_rd, ex_ctrl, ex_is_load, ex_we} !==
                    {m.pc, m.imm, m.a, m.b, m.rd, m.ctrl, m.is_load, m.we}) begin
                    fails++; $display("FAIL rand_fields cyc %0d: pc=%h a=%h b=%h rd=%0d want pc=%h a=%h b=%h rd=%0d",
                                      cyc, ex_pc, ex_rs1_val, ex_rs2_val, ex_rd, m.pc, m.a, m.b, m.rd);
                end
            end
            id_valid = ($urandom_range(0, 3) != 0); id_pc = $urandom; id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3)); id_ctrl = CTRL_W'($urandom);
            id_is_load = ($urandom_range(0, 2) == 0); id_we = ($urandom_range(0, 3) != 0);
            reg_a = $urandom; reg_b = $urandom;
            exr_valid = $urandom_range(0, 1); exr_data = $urandom;
            mem_we = $urandom_range(0, 1); mem_rd = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_we = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            ex_stall = ($urandom_range(0, 4) == 0); ex_flush = ($urandom_range(0, 9) == 0);
            #1;
            lu = m.valid && m.is_load && m.we && m.rd != 0 && id_valid &&
                 (m.rd == id_rs1 || m.rd == id_rs2);
            want_stall = !ex_flush && (ex_stall || lu);
            tests++;
            if (id_stall !== want_stall) begin
                fails++; $display("FAIL rand_id_stall cyc %0d: id_stall=%b want %b", cyc, id_stall, want_stall);
            end
            if (ex_flush)      m.valid = 0;
            else if (ex_stall) m = m;
            else if (lu)       m.valid = 0;
            else begin
                slot_t n;
                n.valid = id_valid; n.pc = id_pc; n.imm = id_imm; n.rd = id_rd;
                n.ctrl = id_ctrl; n.is_load = id_is_load; n.we = id_we;
                n.a = model_operand(m, id_rs1, reg_a);
                n.b = model_operand(m, id_rs2, reg_b);
                m = n;
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward_priority();
        test_x0();
        test_load_use();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
